// File: rtl/reg_file_mp.sv
// Multi-read-port register file with an index-fill initialisation sequencer
// and a per-register pending scoreboard for issue logic.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      init_start,
    output logic                      ready,
    input  logic [NREAD*ADDR_W-1:0]   rd_addr,
    output logic [NREAD*DATA_W-1:0]   rd_data,
    output logic [NREAD-1:0]          rd_pending,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      claim_en,
    input  logic [ADDR_W-1:0]         claim_addr,
    output logic [DEPTH-1:0]          pending_vec
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [DEPTH-1:0]    pending;
    logic [DEPTH-1:0]    pending_next;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                run;
    logic                wr_ok;
    logic                claim_ok;

    assign run         = (state == ST_RUN);
    assign pending_vec = pending;

    // Entry 0 is read-only when hardwired to zero, so its writes and claims are dropped.
    assign wr_ok    = run && wr_en    && !((ZERO_REG != 0) && (wr_addr == '0));
    assign claim_ok = run && claim_en && !((ZERO_REG != 0) && (claim_addr == '0));

    // Claim is applied after the write-back clear so that a same-edge claim wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pending_next = pending;
        if (wr_ok)
            pending_next[wr_addr] = 1'b0;
        if (claim_ok)
            pending_next[claim_addr] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_INIT;
            cnt     <= '0;
            pending <= '0;
            ready   <= 1'b0;
        end else if (init_start) begin
            state   <= ST_INIT;
            cnt     <= '0;
            pending <= '0;
            ready   <= 1'b0;
        end else if (state == ST_INIT) begin
            if (cnt == ADDR_W'(DEPTH - 1)) begin
                state <= ST_RUN;
                ready <= 1'b1;
            end else begin
                cnt <= cnt + ADDR_W'(1);
            end
        end else begin
            pending <= pending_next;
        end
    end

    // NOTE: the array has no reset; the INIT walk overwrites every entry before ready rises.
    always_ff @(posedge clock) begin
        if (state == ST_INIT)
            mem[cnt] <= DATA_W'(cnt);
        else if (wr_ok)
            mem[wr_addr] <= wr_data;
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = '0;
            if (!run)
                data = '0;
            else if ((ZERO_REG != 0) && (addr == '0))
                data = '0;
            else if (wr_en && (wr_addr == addr))
                data = wr_data;
            else
                data = mem[addr];
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
        assign rd_pending[k]               = run && pending[addr];
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the register file.
module tb_reg_file_mp;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int NREAD  = 2;
    localparam int ADDR_W = 5;

    logic                    clock;
    logic                    reset;
    logic                    init_start;
    logic                    ready;
    logic [NREAD*ADDR_W-1:0] rd_addr;
    logic [NREAD*DATA_W-1:0] rd_data;
    logic [NREAD-1:0]        rd_pending;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    claim_en;
    logic [ADDR_W-1:0]       claim_addr;
    logic [DEPTH-1:0]        pending_vec;

    reg_file_mp #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NREAD(NREAD), .ZERO_REG(1)
    ) dut (
        .clock(clock), .reset(reset), .init_start(init_start), .ready(ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .pending_vec(pending_vec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the file is either counting down a fresh fill or usable.
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic [DEPTH-1:0]  m_pend  = '0;
    int                m_left  = DEPTH;
    logic              m_ready = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_left  = DEPTH;
            m_pend  = '0;
            m_ready = 1'b0;
        end else if (init_start) begin
            m_left  = DEPTH;
            m_pend  = '0;
            m_ready = 1'b0;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] = DATA_W'(i);
                m_ready = 1'b1;
            end
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]  = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (claim_en && claim_addr != 0)
                m_pend[claim_addr] = 1'b1;
        end
    end

    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
        if (!m_ready || a == 0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    always @(negedge clock) begin
        if (cmp_en) begin
            check("model_ready", ready, m_ready);
            check("model_pending_vec", pending_vec, m_pend);
            for (int k = 0; k < NREAD; k++) begin
                logic [ADDR_W-1:0] a;
                a = rd_addr[k*ADDR_W +: ADDR_W];
                check($sformatf("model_rd_data%0d_a%0d", k, a), rd_data[k*DATA_W +: DATA_W], exp_rd(a));
                check($sformatf("model_rd_pending%0d_a%0d", k, a), rd_pending[k],
                      m_ready ? m_pend[a] : 1'b0);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        wr_en = 0; claim_en = 0; init_start = 0;
        wr_addr = '0; claim_addr = '0; wr_data = '0;
    endtask

    task automatic ready_timing(input string tag);
        for (int e = 1; e <= 31; e++) step();
        check({tag, "_ready_after_31"}, ready, 1'b0);
        step();
        check({tag, "_ready_after_32"}, ready, 1'b1);
    endtask

    initial begin
        reset = 0;
        idle();
        set_rd(0, 0);
        #2 reset = 1;
        #1 cmp_en = 1;
        check("reset_ready", ready, 1'b0);
        check("reset_pending_vec", pending_vec, '0);
        check("reset_rd_data", rd_data, '0);
        check("reset_rd_pending", rd_pending, '0);
        step(); step();
        reset = 0;
        ready_timing("init");

        // Fill pattern on both ports.
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));
            #1;
            check($sformatf("fill_p0_%0d", i), rd_data[31:0], 64'(i));
            check($sformatf("fill_p1_%0d", i), rd_data[63:32], 64'(DEPTH - 1 - i));
        end
        set_rd(7, 31);
        #1;
        check("fill_7", rd_data[31:0], 64'h7);
        check("fill_31", rd_data[63:32], 64'h1F);

        // Bypass then array readback.
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        set_rd(5, 6);
        #1;
        check("bypass_same_cycle", rd_data[31:0], 64'hDEADBEEF);
        check("bypass_other_port", rd_data[63:32], 64'h6);
        step();
        wr_en = 0;
        #1;
        check("bypass_after_edge", rd_data[31:0], 64'hDEADBEEF);

        // Hardwired zero entry.
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
        claim_en = 1; claim_addr = 0;
        set_rd(0, 0);
        #1;
        check("zero_read_during_write", rd_data[31:0], 64'h0);
        step();
        idle();
        #1;
        check("zero_read_after", rd_data[31:0], 64'h0);
        check("zero_pending", pending_vec[0], 1'b0);

        // Scoreboard on register 9.
        claim_en = 1; claim_addr = 9;
        step();
        idle();
        set_rd(3, 9);
        #1;
        check("claim9_pending_vec", pending_vec[9], 1'b1);
        check("claim9_rd_pending", rd_pending[1], 1'b1);
        wr_en = 1; wr_addr = 9; wr_data = 32'hAA;
        #1;
        check("claim9_raw_pending", rd_pending[1], 1'b1);
        step();
        idle();
        #1;
        check("write9_clears", pending_vec[9], 1'b0);
        wr_en = 1; wr_addr = 9; wr_data = 32'h55;
        claim_en = 1; claim_addr = 9;
        step();
        idle();
        #1;
        check("claim_write9_pending", pending_vec[9], 1'b1);
        check("claim_write9_data", rd_data[63:32], 64'h55);

        // Re-init.
        wr_en = 1; wr_addr = 3; wr_data = 32'hFF;
        step();
        idle();
        set_rd(3, 9);
        #1;
        check("reinit_pre_entry3", rd_data[31:0], 64'hFF);
        init_start = 1;
        step();
        init_start = 0;
        #1;
        check("reinit_ready_low", ready, 1'b0);
        check("reinit_pending_clear", pending_vec, '0);
        check("reinit_rd_forced", rd_data, '0);
        for (int e = 1; e <= 31; e++) step();
        check("reinit_ready_after_31", ready, 1'b0);
        step();
        check("reinit_ready_after_32", ready, 1'b1);
        check("reinit_entry3", rd_data[31:0], 64'h3);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            init_start = ($urandom_range(0, 299) == 0);
            wr_en      = $urandom_range(0, 1);
            claim_en   = ($urandom_range(0, 2) == 0);
            wr_addr    = $urandom_range(0, 1) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            claim_addr = $urandom_range(0, 1) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            wr_data    = $urandom;
            set_rd($urandom_range(0, 1) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom),
                   $urandom_range(0, 1) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom));
            step();
        end
        idle();
        for (int e = 0; e < 40; e++) step();

        // Asynchronous reset mid-RUN.
        claim_en = 1; claim_addr = 9;
        step();
        idle();
        set_rd(9, 9);
        wr_en = 1; wr_addr = 9; wr_data = 32'h77;
        #1;
        check("run_reset_pre_pending", pending_vec[9], 1'b1);
        check("run_reset_pre_data", rd_data[31:0], 64'h77);
        reset = 1;
        #1;
        check("run_reset_ready", ready, 1'b0);
        check("run_reset_pending_vec", pending_vec, '0);
        check("run_reset_rd_data", rd_data, '0);
        check("run_reset_rd_pending", rd_pending, '0);
        step();
        idle();
        reset = 0;
        ready_timing("run_reset");

        // Asynchronous reset mid-INIT with ignored traffic.
        init_start = 1;
        step();
        init_start = 0;
        wr_en = 1; wr_addr = 12; wr_data = 32'hBAD;
        claim_en = 1; claim_addr = 12;
        set_rd(12, 13);
        for (int e = 0; e < 10; e++) step();
        check("init_traffic_pending", pending_vec, '0);
        reset = 1;
        #1;
        check("init_reset_ready", ready, 1'b0);
        check("init_reset_pending_vec", pending_vec, '0);
        step();
        reset = 0;
        ready_timing("init_reset");
        idle();
        #1;
        check("init_ignored_write", rd_data[31:0], 64'hC);
        check("init_ignored_claim", pending_vec[12], 1'b0);
        step();

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
